// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Brief    : States, event codes and segment codes for the status display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW_U = 3'd1,
    ST_SHOW_E = 3'd2,
    ST_SHOW_A = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

  localparam logic [1:0] EVT_UNLOCK  = 2'b00;
  localparam logic [1:0] EVT_ERROR   = 2'b01;
  localparam logic [1:0] EVT_LOCKOUT = 2'b10;
  localparam logic [1:0] EVT_ALERT   = 2'b11;

  localparam logic [3:0] SEG_U            = 4'h7;
  localparam logic [3:0] SEG_E            = 4'h5;
  localparam logic [3:0] SEG_L            = 4'h6;
  localparam logic [3:0] SEG_A            = 4'hF;
  localparam logic [3:0] SEG_BLANK1       = 4'hF;
  localparam logic [3:0] SEG_BLANK2_SHIFT = 4'h0;

  function automatic logic [3:0] sat9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Lockout step count: zero would show nothing useful, so it counts as one.
  function automatic logic [3:0] clamp19(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : sat9(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_ctrl_if.sv
// ============================================================================
// Module   : display_ctrl_if
// Brief    : Valid/ready status-event channel into the display sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface display_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [3:0] evt_arg;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_arg,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_arg,
    output evt_ready
  );
endinterface

`default_nettype wire

// File: rtl/display_ctrl_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Modulo-PERIOD cycle counter; tick is high on the last enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int unsigned PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  generate
    if (PERIOD <= 1) begin : g_passthru
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clr};
      assign tick = en;
    end else begin : g_count
      localparam int unsigned W = $clog2(PERIOD);
      localparam logic [W-1:0] LAST = W'(PERIOD - 1);

      logic [W-1:0] cnt_q;
      logic [W-1:0] cnt_d;

      assign tick = en && (cnt_q == LAST);

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = tick ? '0 : cnt_q + W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/display_ctrl.sv
// ============================================================================
// Module   : display_ctrl
// Brief    : Arbitrates live PIN view and timed status messages for seven_seg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 10_000_000,
  parameter int unsigned TICK_CYCLES  = 10_000_000,
  parameter int unsigned BLINK_CYCLES = 2_500_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_ctrl_if.slave        evt,
  input  logic                 force_idle,
  input  logic [3:0]           live_digit,
  input  logic [1:0]           live_idx,
  output logic [3:0]           bcd1,
  output logic [3:0]           bcd2,
  output logic                 shift,
  output logic                 busy
);

  state_e     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       phase_q, phase_d;
  logic [3:0] bcd1_q, bcd1_d;
  logic [3:0] bcd2_q, bcd2_d;
  logic       shift_q, shift_d;

  logic ready;
  logic accept;
  logic restart;
  logic in_show;
  logic hold_tick;
  logic lock_tick;
  logic blink_tick;

  assign ready         = (state_q != ST_LOCK) && !force_idle;
  assign evt.evt_ready = ready;
  assign accept        = evt.evt_valid && ready;
  assign in_show       = (state_q == ST_SHOW_U) || (state_q == ST_SHOW_E) ||
                         (state_q == ST_SHOW_A);

  // Every state entry, preemption or abort restarts all timers from zero.
  assign restart = force_idle || accept || (state_d != state_q);

  tick_prescaler #(.PERIOD(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (in_show),
    .tick  (hold_tick)
  );

  tick_prescaler #(.PERIOD(TICK_CYCLES)) u_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (state_q == ST_LOCK),
    .tick  (lock_tick)
  );

  tick_prescaler #(.PERIOD(BLINK_CYCLES)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (state_q == ST_SHOW_E),
    .tick  (blink_tick)
  );

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    phase_d = phase_q;
    if (force_idle) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (evt.evt_code)
        EVT_UNLOCK: state_d = ST_SHOW_U;
        EVT_ERROR: begin
          state_d = ST_SHOW_E;
          digit_d = sat9(evt.evt_arg);
        end
        EVT_LOCKOUT: begin
          state_d = ST_LOCK;
          digit_d = clamp19(evt.evt_arg);
        end
        default: begin
          state_d = ST_SHOW_A;
          digit_d = sat9(evt.evt_arg);
        end
      endcase
    end else begin
      case (state_q)
        ST_SHOW_U, ST_SHOW_A: begin
          if (hold_tick) state_d = ST_IDLE;
        end
        ST_SHOW_E: begin
          if (hold_tick) state_d = ST_IDLE;
          if (blink_tick) phase_d = ~phase_q;
        end
        ST_LOCK: begin
          if (lock_tick) begin
            if (digit_q == 4'd1) begin
              state_d = ST_IDLE;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
    if (restart) phase_d = 1'b0;
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    bcd1_d  = SEG_BLANK1;
    bcd2_d  = SEG_BLANK1;
    shift_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        bcd1_d = live_digit;
        bcd2_d = {2'b00, live_idx};
      end
      ST_SHOW_U: begin
        bcd1_d  = SEG_BLANK1;
        bcd2_d  = SEG_U;
        shift_d = 1'b1;
      end
      ST_SHOW_E: begin
        bcd1_d  = digit_d;
        bcd2_d  = phase_d ? SEG_BLANK2_SHIFT : SEG_E;
        shift_d = 1'b1;
      end
      ST_SHOW_A: begin
        bcd1_d  = digit_d;
        bcd2_d  = SEG_A;
        shift_d = 1'b1;
      end
      ST_LOCK: begin
        bcd1_d  = digit_d;
        bcd2_d  = SEG_L;
        shift_d = 1'b1;
      end
      default: begin
        bcd1_d  = SEG_BLANK1;
        bcd2_d  = SEG_BLANK1;
        shift_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      digit_q <= 4'd0;
      phase_q <= 1'b0;
      bcd1_q  <= SEG_BLANK1;
      bcd2_q  <= SEG_BLANK1;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      phase_q <= phase_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      shift_q <= shift_d;
    end
  end

  assign bcd1  = bcd1_q;
  assign bcd2  = bcd2_q;
  assign shift = shift_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_display_ctrl.sv
// ============================================================================
// Module   : tb_display_ctrl
// Brief    : Directed table-driven bench for display_ctrl (HOLD=8, TICK=10, BLINK=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       force_idle;
  logic [3:0] live_digit;
  logic [1:0] live_idx;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic       shift;
  logic       busy;

  display_ctrl_if evt_if ();

  always #5 clk = ~clk;

  display_ctrl #(
    .HOLD_CYCLES  (8),
    .TICK_CYCLES  (10),
    .BLINK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt        (evt_if),
    .force_idle (force_idle),
    .live_digit (live_digit),
    .live_idx   (live_idx),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .shift      (shift),
    .busy       (busy)
  );

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic [3:0] arg;
    logic       f;
    logic [3:0] ld;
    logic [1:0] li;
    int         n;
    logic [3:0] e1;
    logic [3:0] e2;
    logic       es;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic v, input logic [1:0] code, input logic [3:0] arg,
                     input logic f, input logic [3:0] ld, input logic [1:0] li,
                     input int n, input logic [3:0] e1, input logic [3:0] e2,
                     input logic es, input logic eb, input logic er);
    vec_t t;
    t.v = v; t.code = code; t.arg = arg; t.f = f; t.ld = ld; t.li = li; t.n = n;
    t.e1 = e1; t.e2 = e2; t.es = es; t.eb = eb; t.er = er;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                            input logic es, input logic eb, input logic er);
    check({tag, ".bcd1"}, bcd1, e1);
    check({tag, ".bcd2"}, bcd2, e2);
    check({tag, ".shift"}, {3'b000, shift}, {3'b000, es});
    check({tag, ".busy"}, {3'b000, busy}, {3'b000, eb});
    check({tag, ".ready"}, {3'b000, evt_if.evt_ready}, {3'b000, er});
  endtask

  task automatic drive(input logic v, input logic [1:0] code, input logic [3:0] arg,
                       input logic f, input logic [3:0] ld, input logic [1:0] li);
    evt_if.evt_valid = v;
    evt_if.evt_code  = code;
    evt_if.evt_arg   = arg;
    force_idle       = f;
    live_digit       = ld;
    live_idx         = li;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //   v  code   arg  f  ld li  n   bcd1 bcd2 sh bz rdy
    add(0, 2'd0, 4'd0, 0, 3, 2, 1, 4'h3, 4'h2, 0, 0, 1);
    add(0, 2'd0, 4'd0, 0, 7, 1, 1, 4'h7, 4'h1, 0, 0, 1);
    add(1, 2'd0, 4'd0, 0, 7, 1, 1, 4'hF, 4'h7, 1, 1, 1);   // UNLOCK at k
    add(0, 2'd0, 4'd0, 0, 7, 1, 7, 4'hF, 4'h7, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);   // IDLE at k+8
    add(1, 2'd1, 4'd12, 0, 4, 3, 1, 4'h9, 4'h5, 1, 1, 1);  // ERROR, arg 12
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h9, 4'h5, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h9, 4'h0, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h9, 4'h5, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h9, 4'h0, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);
    add(1, 2'd3, 4'd4, 0, 4, 3, 1, 4'h4, 4'hF, 1, 1, 1);   // ALERT at k
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h4, 4'hF, 1, 1, 1);
    add(1, 2'd1, 4'd2, 0, 4, 3, 1, 4'h2, 4'h5, 1, 1, 1);   // ERROR preempts at k+3
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h2, 4'h5, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h2, 4'h0, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h2, 4'h5, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 2, 4'h2, 4'h0, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);   // hold ends at k+11
    add(1, 2'd2, 4'd3, 0, 4, 3, 1, 4'h3, 4'h6, 1, 1, 0);   // LOCKOUT 3 at k
    add(1, 2'd0, 4'd0, 0, 4, 3, 9, 4'h3, 4'h6, 1, 1, 0);   // UNLOCK held, refused
    add(1, 2'd0, 4'd0, 0, 4, 3, 10, 4'h2, 4'h6, 1, 1, 0);
    add(1, 2'd0, 4'd0, 0, 4, 3, 10, 4'h1, 4'h6, 1, 1, 0);
    add(1, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);   // IDLE at k+30
    add(1, 2'd0, 4'd0, 0, 4, 3, 1, 4'hF, 4'h7, 1, 1, 1);   // held UNLOCK taken
    add(0, 2'd0, 4'd0, 0, 4, 3, 7, 4'hF, 4'h7, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);
    add(1, 2'd2, 4'd0, 0, 4, 3, 1, 4'h1, 4'h6, 1, 1, 0);   // LOCKOUT 0 -> one step
    add(0, 2'd0, 4'd0, 0, 4, 3, 9, 4'h1, 4'h6, 1, 1, 0);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);
    add(1, 2'd0, 4'd0, 1, 4, 3, 1, 4'h4, 4'h3, 0, 0, 0);   // force blocks event
    add(1, 2'd3, 4'd15, 0, 4, 3, 1, 4'h9, 4'hF, 1, 1, 1);
    add(1, 2'd1, 4'd1, 1, 4, 3, 1, 4'h4, 4'h3, 0, 0, 0);   // force beats event
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);
    add(1, 2'd2, 4'd5, 0, 4, 3, 1, 4'h5, 4'h6, 1, 1, 0);
    add(0, 2'd0, 4'd0, 0, 4, 3, 4, 4'h5, 4'h6, 1, 1, 0);
    add(0, 2'd0, 4'd0, 1, 4, 3, 1, 4'h4, 4'h3, 0, 0, 0);   // force out of LOCK
    add(1, 2'd0, 4'd0, 0, 4, 3, 1, 4'hF, 4'h7, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 7, 4'hF, 4'h7, 1, 1, 1);
    add(0, 2'd0, 4'd0, 0, 4, 3, 1, 4'h4, 4'h3, 0, 0, 1);

    rst_n = 1'b0;
    drive(0, 2'd0, 4'd0, 0, 4'd3, 2'd2);
    repeat (2) @(negedge clk);
    check_outs("reset", 4'hF, 4'hF, 0, 0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].arg, vecs[i].f, vecs[i].ld, vecs[i].li);
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        check_outs($sformatf("row%0d.c%0d", i, c), vecs[i].e1, vecs[i].e2,
                   vecs[i].es, vecs[i].eb, vecs[i].er);
      end
    end

    // force_idle pulls evt_ready low before the edge, even while showing a message
    drive(1, 2'd0, 4'd0, 0, 4'd4, 2'd3);
    step();
    check_outs("fpre.show", 4'hF, 4'h7, 1, 1, 1);
    drive(1, 2'd3, 4'd2, 1, 4'd4, 2'd3);
    #1;
    check("fpre.ready", {3'b000, evt_if.evt_ready}, 4'h0);
    check("fpre.busy", {3'b000, busy}, 4'h1);
    step();
    check_outs("fpre.idle", 4'h4, 4'h3, 0, 0, 0);

    // Asynchronous reset in the middle of a lockout
    drive(1, 2'd2, 4'd7, 0, 4'd4, 2'd3);
    step();
    check_outs("rlock.enter", 4'h7, 4'h6, 1, 1, 0);
    drive(0, 2'd0, 4'd0, 0, 4'd3, 2'd2);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rlock.async", 4'hF, 4'hF, 0, 0, 1);
    step();
    check_outs("rlock.held", 4'hF, 4'hF, 0, 0, 1);
    rst_n = 1'b1;
    step();
    check_outs("rlock.idle", 4'h3, 4'h2, 0, 0, 1);
    repeat (12) step();
    check_outs("rlock.stay", 4'h3, 4'h2, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
